// File: rtl/key_sw_io_device_pkg.sv
// Shared constants for the KEY/SW input peripheral: register map,
// control-register bit positions and input group widths.
package key_sw_io_device_pkg;

  localparam logic [31:0] ADDR_KDATA_DEF = 32'hF0000010;
  localparam logic [31:0] ADDR_SDATA_DEF = 32'hF0000014;
  localparam logic [31:0] ADDR_KCTRL_DEF = 32'hF0000110;
  localparam logic [31:0] ADDR_SCTRL_DEF = 32'hF0000114;

  localparam int CTRL_READY = 0;
  localparam int CTRL_OVR   = 2;
  localparam int CTRL_IE    = 4;

  localparam int KEY_W = 4;
  localparam int SW_W  = 10;

endpackage

// File: rtl/key_sw_io_device_if.sv
// Memory-stage bus between the pipeline load/store path and the peripheral.
// Single-cycle access: a load or store is taken on the clock edge it is
// presented at; rdData/rdHit answer combinationally from addr.
interface key_sw_io_device_if #(
  parameter int DBITS = 32
);
  logic [DBITS-1:0] addr;
  logic             isLoad;
  logic             isStore;
  logic [DBITS-1:0] wrData;
  logic [DBITS-1:0] rdData;
  logic             rdHit;

  modport master (output addr, isLoad, isStore, wrData, input rdData, rdHit);
  modport slave  (input addr, isLoad, isStore, wrData, output rdData, rdHit);
endinterface

// File: rtl/key_sw_io_device_io_debouncer.sv
// Two-flop synchroniser followed by a per-group stability counter; stable
// takes the synchronised value once it has differed for DEBOUNCE_CYCLES cycles.
module io_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_BITS        = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable,
  output logic             changed
);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

  logic [WIDTH-1:0]    syncA;
  logic [WIDTH-1:0]    syncB;
  logic [CNT_BITS-1:0] cnt;

  // Pulses in the same cycle stable is loaded, so the top can update flags on that edge.
  assign changed = (syncB != stable) && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncA  <= '0;
      syncB  <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      syncA <= din;
      syncB <= syncA;
      if (syncB == stable) begin
        cnt <= '0;
      end else if (changed) begin
        stable <= syncB;
        cnt    <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/key_sw_io_device.sv
// KEY/SW input peripheral: debounced data registers plus ready/overrun/ie
// control-status registers and a level interrupt, on the memory-stage bus.
module key_sw_io_device
  import key_sw_io_device_pkg::*;
#(
  parameter int          DBITS           = 32,
  parameter int          DEBOUNCE_CYCLES = 250000,
  parameter int          CNT_BITS        = 20,
  parameter logic [31:0] ADDR_KDATA      = ADDR_KDATA_DEF,
  parameter logic [31:0] ADDR_SDATA      = ADDR_SDATA_DEF,
  parameter logic [31:0] ADDR_KCTRL      = ADDR_KCTRL_DEF,
  parameter logic [31:0] ADDR_SCTRL      = ADDR_SCTRL_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [KEY_W-1:0]    KEY,
  input  logic [SW_W-1:0]     SW,
  key_sw_io_device_if.slave   bus,
  output logic                intr
);
  logic [KEY_W-1:0] kStable;
  logic [SW_W-1:0]  sStable;
  logic             kChg, sChg;
  logic             kReady, kOvr, kIe;
  logic             sReady, sOvr, sIe;

  // KEY is active-low on the board; invert so a pressed button reads 1.
  io_debouncer #(.WIDTH(KEY_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_BITS(CNT_BITS))
    keyDeb (.clk(clk), .reset(reset), .din(~KEY), .stable(kStable), .changed(kChg));

  io_debouncer #(.WIDTH(SW_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_BITS(CNT_BITS))
    swDeb (.clk(clk), .reset(reset), .din(SW), .stable(sStable), .changed(sChg));

  logic hitKData, hitSData, hitKCtrl, hitSCtrl;
  assign hitKData = (bus.addr == DBITS'(ADDR_KDATA));
  assign hitSData = (bus.addr == DBITS'(ADDR_SDATA));
  assign hitKCtrl = (bus.addr == DBITS'(ADDR_KCTRL));
  assign hitSCtrl = (bus.addr == DBITS'(ADDR_SCTRL));

  logic kDataRd, sDataRd, kCtrlWr, sCtrlWr;
  assign kDataRd = bus.isLoad  && hitKData;
  assign sDataRd = bus.isLoad  && hitSData;
  assign kCtrlWr = bus.isStore && hitKCtrl;
  assign sCtrlWr = bus.isStore && hitSCtrl;

  // Later assignments take priority: an overrun event beats a W0C clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kReady <= 1'b0;
      kOvr   <= 1'b0;
      kIe    <= 1'b0;
    end else begin
      if (kCtrlWr) begin
        kIe <= bus.wrData[CTRL_IE];
        if (!bus.wrData[CTRL_OVR]) kOvr <= 1'b0;
      end
      if (kChg) begin
        if (kReady && !kDataRd) kOvr <= 1'b1;
        kReady <= 1'b1;
      end else if (kDataRd) begin
        kReady <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sReady <= 1'b0;
      sOvr   <= 1'b0;
      sIe    <= 1'b0;
    end else begin
      if (sCtrlWr) begin
        sIe <= bus.wrData[CTRL_IE];
        if (!bus.wrData[CTRL_OVR]) sOvr <= 1'b0;
      end
      if (sChg) begin
        if (sReady && !sDataRd) sOvr <= 1'b1;
        sReady <= 1'b1;
      end else if (sDataRd) begin
        sReady <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.rdData = '0;
    if (hitKData) begin
      bus.rdData[KEY_W-1:0] = kStable;
    end else if (hitSData) begin
      bus.rdData[SW_W-1:0] = sStable;
    end else if (hitKCtrl) begin
      bus.rdData[CTRL_READY] = kReady;
      bus.rdData[CTRL_OVR]   = kOvr;
      bus.rdData[CTRL_IE]    = kIe;
    end else if (hitSCtrl) begin
      bus.rdData[CTRL_READY] = sReady;
      bus.rdData[CTRL_OVR]   = sOvr;
      bus.rdData[CTRL_IE]    = sIe;
    end
  end

  assign bus.rdHit = hitKData | hitSData | hitKCtrl | hitSCtrl;
  assign intr      = (kReady & kIe) | (sReady & sIe);
endmodule

// File: tb/tb_key_sw_io_device.sv
// Directed bench for key_sw_io_device with a short debounce window (4 cycles).
module tb_key_sw_io_device;
  localparam logic [31:0] A_KDATA = 32'hF0000010;
  localparam logic [31:0] A_SDATA = 32'hF0000014;
  localparam logic [31:0] A_KCTRL = 32'hF0000110;
  localparam logic [31:0] A_SCTRL = 32'hF0000114;

  logic       clk;
  logic       reset;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic       intr;
  int         n_cmp = 0;
  int         n_bad = 0;

  key_sw_io_device_if #(.DBITS(32)) bus ();

  key_sw_io_device #(.DBITS(32), .DEBOUNCE_CYCLES(4), .CNT_BITS(4)) dut (
    .clk(clk), .reset(reset), .KEY(KEY), .SW(SW), .bus(bus), .intr(intr)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: all activity happens 1 ns after a rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    bus.addr    = a;
    bus.isLoad  = 1'b0;
    bus.isStore = 1'b0;
    #1;
    d = bus.rdData;
  endtask

  task automatic do_load(input logic [31:0] a, output logic [31:0] d);
    bus.addr    = a;
    bus.isLoad  = 1'b1;
    bus.isStore = 1'b0;
    #1;
    d = bus.rdData;
    tick();
    bus.isLoad = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    bus.addr    = a;
    bus.wrData  = d;
    bus.isStore = 1'b1;
    bus.isLoad  = 1'b0;
    tick();
    bus.isStore = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; KEY = 4'hF; SW = 10'h000;
    bus.addr = '0; bus.isLoad = 1'b0; bus.isStore = 1'b0; bus.wrData = '0;
    tick(20);
    n_cmp++; if (intr !== 1'b0) begin n_bad++; $display("FAIL rst_intr: got %b expected 0", intr); end
    peek(A_KDATA, d); n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_kdata: got %h expected 0", d); end
    peek(A_SDATA, d); n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_sdata: got %h expected 0", d); end
    reset = 1'b0;
    tick();
    peek(A_KCTRL, d); n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_kctrl: got %h expected 0", d); end
    peek(A_SCTRL, d); n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_sctrl: got %h expected 0", d); end
    n_cmp++; if (intr !== 1'b0) begin n_bad++; $display("FAIL rst_intr_post: got %b expected 0", intr); end
  endtask

  task automatic test_key_press();
    logic [31:0] d;
    KEY = 4'hD;
    tick(5);
    peek(A_KDATA, d); n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL key_early: got %h expected 0", d); end
    tick();
    peek(A_KDATA, d); n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL key_kdata: got %h expected 2", d); end
    peek(A_KCTRL, d); n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL key_kctrl: got %h expected 1", d); end
    do_load(A_KDATA, d); n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL key_load: got %h expected 2", d); end
    peek(A_KCTRL, d); n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL key_ready_clr: got %h expected 0", d); end
  endtask

  task automatic test_sw_bounce();
    logic [31:0] d;
    for (int i = 0; i < 10; i++) begin
      SW = (i % 2 == 0) ? 10'h001 : 10'h000;
      for (int j = 0; j < 2; j++) begin
        tick();
        peek(A_SDATA, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL sw_bounce[%0d]: got %h expected 0", i, d); end
      end
    end
    SW = 10'h3FF;
    tick(8);
    peek(A_SDATA, d); n_cmp++; if (d !== 32'h3FF) begin n_bad++; $display("FAIL sw_final: got %h expected 3ff", d); end
    peek(A_SCTRL, d); n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL sw_ready: got %h expected 1", d); end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    do_load(A_SDATA, d); n_cmp++; if (d !== 32'h3FF) begin n_bad++; $display("FAIL ovr_load0: got %h expected 3ff", d); end
    SW = 10'h001;
    tick(8);
    peek(A_SCTRL, d); n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL ovr_first: got %h expected 1", d); end
    SW = 10'h003;
    tick(8);
    peek(A_SCTRL, d); n_cmp++; if (d !== 32'h5) begin n_bad++; $display("FAIL ovr_set: got %h expected 5", d); end
    do_store(A_SCTRL, 32'h5);
    peek(A_SCTRL, d); n_cmp++; if (d !== 32'h5) begin n_bad++; $display("FAIL ovr_keep: got %h expected 5", d); end
    do_store(A_SCTRL, 32'h0);
    peek(A_SCTRL, d); n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL ovr_w0c: got %h expected 1", d); end
    do_store(A_SDATA, 32'hFFFF);
    peek(A_SDATA, d); n_cmp++; if (d !== 32'h3) begin n_bad++; $display("FAIL data_store_ign: got %h expected 3", d); end
    peek(32'hF0000012, d); n_cmp++; if (d !== 32'h0 || bus.rdHit !== 1'b0) begin n_bad++; $display("FAIL addr_miss: got %h/%b expected 0/0", d, bus.rdHit); end
    peek(A_SDATA, d); n_cmp++; if (bus.rdHit !== 1'b1) begin n_bad++; $display("FAIL addr_hit: got %b expected 1", bus.rdHit); end
    do_load(A_SDATA, d); n_cmp++; if (d !== 32'h3) begin n_bad++; $display("FAIL ovr_load: got %h expected 3", d); end
    peek(A_SCTRL, d); n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL ovr_clr: got %h expected 0", d); end
  endtask

  task automatic test_intr();
    logic [31:0] d;
    do_store(A_KCTRL, 32'h10);
    peek(A_KCTRL, d); n_cmp++; if (d !== 32'h10) begin n_bad++; $display("FAIL intr_ie: got %h expected 10", d); end
    KEY = 4'hC;
    tick(5);
    n_cmp++; if (intr !== 1'b0) begin n_bad++; $display("FAIL intr_early: got %b expected 0", intr); end
    tick();
    n_cmp++; if (intr !== 1'b1) begin n_bad++; $display("FAIL intr_rise: got %b expected 1", intr); end
    peek(A_KCTRL, d); n_cmp++; if (d !== 32'h11) begin n_bad++; $display("FAIL intr_kctrl: got %h expected 11", d); end
    do_load(A_KDATA, d); n_cmp++; if (d !== 32'h3) begin n_bad++; $display("FAIL intr_load: got %h expected 3", d); end
    n_cmp++; if (intr !== 1'b0) begin n_bad++; $display("FAIL intr_fall: got %b expected 0", intr); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    KEY = 4'hE;
    tick(2);
    reset = 1'b1;
    #1;
    n_cmp++; if (intr !== 1'b0) begin n_bad++; $display("FAIL mid_intr: got %b expected 0", intr); end
    peek(A_KDATA, d); n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL mid_kdata: got %h expected 0", d); end
    peek(A_KCTRL, d); n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL mid_kctrl: got %h expected 0", d); end
    peek(A_SDATA, d); n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL mid_sdata: got %h expected 0", d); end
    tick(2);
    reset = 1'b0;
    tick(5);
    peek(A_KDATA, d); n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL post_early: got %h expected 0", d); end
    tick();
    peek(A_KDATA, d); n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL post_kdata: got %h expected 1", d); end
    peek(A_KCTRL, d); n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL post_kctrl: got %h expected 1", d); end
    peek(A_SDATA, d); n_cmp++; if (d !== 32'h3) begin n_bad++; $display("FAIL post_sdata: got %h expected 3", d); end
    peek(A_SCTRL, d); n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL post_sctrl: got %h expected 1", d); end
  endtask

  initial begin
    test_reset();
    test_key_press();
    test_sw_bounce();
    test_overrun();
    test_intr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
